mod_exp_engine: RTL and testbench

//  Iterative modular exponentiator: result = base^exponent mod modulus.

---
 rtl/mod_exp_engine.sv | 201 ++++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// mod_exp_engine
// Iterative modular exponentiator: result = base^exponent mod modulus.
// It uses right-to-left square-and-multiply. Each exponent bit costs one
// MUL phase of N cycles plus one STEP cycle. During MUL, two bit-serial
// interleaved modular multipliers run side by side:
//   - multiplier 0 forms R*B mod n;
//   - multiplier 1 forms B*B mod n.
//
// Ports (N = 2*WIDTH):
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous, active-high; aborts and returns to IDLE
//   start     in   1  one-cycle request, honoured only in IDLE
//   base      in   N  message, latched on the accepted start edge
//   exponent  in   N  e or d, latched on the accepted start edge
//   modulus   in   N  n, latched on the accepted start edge
//   result    out  N  base^exponent mod modulus; held until next start
//   busy      out  1  high from the cycle after start through finish
//   finish    out  1  one-cycle pulse; result/error valid
//   error     out  1  operand fault (n==0 or base>=n); held until next start

module mod_exp_engine #(
  parameter int WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   base,
  input  logic [2*WIDTH-1:0]   exponent,
  input  logic [2*WIDTH-1:0]   modulus,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 finish,
  output logic                 error
);

  localparam int N  = 2 * WIDTH;
  // One spare bit, so the counter can never wrap even at the maximum value.
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_STEP,
    S_DONE
  } state_t;

  state_t          state_reg;
  logic [N-1:0]    e_reg;
  logic [N-1:0]    b_reg;
  logic [N-1:0]    r_reg;
  logic [N-1:0]    n_reg;
  logic [N-1:0]    scan_reg;     // copy of B shifted left; MSB is the scanned bit
  logic [N-1:0]    result_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            finish_reg;
  logic            error_reg;

  logic [N-1:0]    addend [2];
  logic [N-1:0]    prod   [2];
  logic [N-1:0]    e_next;
  logic [N-1:0]    r_next;

  assign addend[0] = r_reg;      // R*B
  assign addend[1] = b_reg;      // B*B

  assign e_next = e_reg >> 1;
  assign r_next = e_reg[0] ? prod[0] : r_reg;

  // Interleaved modular multipliers. At the start of MUL, P is 0.
  // Each cycle computes P = 2P mod n, then adds a (mod n) when the scanned
  // bit is 1. All work is done in N+1 bits, so 2P and P+a (both < 2n)
  // never drop a carry, even when n has its MSB set.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mul
      logic [N-1:0] p_reg;
      logic [N:0]   dbl;
      logic [N:0]   dbl_red;
      logic [N:0]   sum;
      logic [N:0]   sum_red;
      logic [N-1:0] p_next;
      logic         sum_red_unused;

      always_comb begin
        dbl     = {p_reg, 1'b0};
        dbl_red = (dbl >= {1'b0, n_reg}) ? (dbl - {1'b0, n_reg}) : dbl;
        sum     = dbl_red + {1'b0, addend[gi]};
        sum_red = (sum >= {1'b0, n_reg}) ? (sum - {1'b0, n_reg}) : sum;
        p_next  = scan_reg[N-1] ? sum_red[N-1:0] : dbl_red[N-1:0];
      end

      // After the reduction the top bit is always zero.
      assign sum_red_unused = sum_red[N];

      // P is cleared outside MUL, so each MUL phase starts from zero.
      // In STEP, P still holds the finished product.
      always_ff @(posedge clk) begin
        if (reset || state_reg != S_MUL) begin
          p_reg <= '0;
        end else begin
          p_reg <= p_next;
        end
      end

      assign prod[gi] = p_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      e_reg      <= '0;
      b_reg      <= '0;
      r_reg      <= '0;
      n_reg      <= '0;
      scan_reg   <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      finish_reg <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      finish_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            e_reg     <= exponent;
            b_reg     <= base;
            r_reg     <= {{(N-1){1'b0}}, 1'b1};
            n_reg     <= modulus;
            busy_reg  <= 1'b1;
            error_reg <= 1'b0;
            state_reg <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (n_reg == '0 || b_reg >= n_reg) begin
            error_reg  <= 1'b1;
            result_reg <= '0;
            finish_reg <= 1'b1;
            state_reg  <= S_DONE;
          end else if (n_reg == {{(N-1){1'b0}}, 1'b1}) begin
            result_reg <= '0;
            finish_reg <= 1'b1;
            state_reg  <= S_DONE;
          end else if (e_reg == '0) begin
            result_reg <= {{(N-1){1'b0}}, 1'b1};
            finish_reg <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            cnt_reg   <= '0;
            scan_reg  <= b_reg;
            state_reg <= S_MUL;
          end
        end

        S_MUL: begin
          scan_reg <= scan_reg << 1;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) begin
            state_reg <= S_STEP;
          end
        end

        S_STEP: begin
          r_reg <= r_next;
          b_reg <= prod[1];
          e_reg <= e_next;
          if (e_next == '0) begin
            result_reg <= r_next;
            finish_reg <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            cnt_reg   <= '0;
            scan_reg  <= prod[1];   // the next MUL phase scans the new B
            state_reg <= S_MUL;
          end
        end

        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign result = result_reg;
  assign busy   = busy_reg;
  assign finish = finish_reg;
  assign error  = error_reg;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Testbench for mod_exp_engine at WIDTH=8 (N=16).
// The stimulus process pushes an expected record into a scoreboard queue
// for every accepted operation. A separate monitor pops that record on each
// finish pulse and compares result, error, latency and busy duration.

module tb_mod_exp_engine;

  localparam int WIDTH = 8;
  localparam int N     = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] base = '0;
  logic [N-1:0] exponent = '0;
  logic [N-1:0] modulus = '0;
  logic [N-1:0] result;
  logic         busy;
  logic         finish;
  logic         error;

  mod_exp_engine #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .finish   (finish),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         err;
    int           lat;
    int           t0;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   op_id = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_q <= reset;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain modular arithmetic on 64-bit integers.
  // Returns {error, result}.
  function automatic logic [N:0] ref_exp(input longint unsigned b, input longint unsigned e,
                                         input longint unsigned m);
    longint unsigned acc;
    longint unsigned sq;
    longint unsigned ee;
    if (m == 0 || b >= m) return {1'b1, {N{1'b0}}};
    if (m == 1) return '0;
    if (e == 0) return (N+1)'(1);
    acc = 1;
    sq  = b;
    ee  = e;
    while (ee != 0) begin
      if ((ee & 1) != 0) acc = (acc * sq) % m;
      sq = (sq * sq) % m;
      ee = ee >> 1;
    end
    return {1'b0, acc[N-1:0]};
  endfunction

  function automatic int bit_len(input longint unsigned e);
    int n = 0;
    while (e != 0) begin
      n++;
      e = e >> 1;
    end
    return n;
  endfunction

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    exp_t x;
    if (rst_q) busy_cnt = 0;
    if (busy) busy_cnt++;
    if (finish) begin
      if (sb.size() == 0) begin
        check("unexpected_finish", 1, 0);
      end else begin
        x = sb.pop_front();
        $display("op %0d: result=%0d error=%0b latency=%0d (expected %0d/%0b/%0d)",
                 x.id, result, error, cyc - x.t0 + 1, x.res, x.err, x.lat);
        check("result", result, x.res);
        check("error", error, x.err);
        check("latency", cyc - x.t0 + 1, x.lat);
        check("busy_cycles", busy_cnt, x.lat);
      end
      busy_cnt = 0;
    end
  end

  // Issue one operation. want >= 0 forces the result to a hand-computed
  // value; interfere > 0 pulses a conflicting start that many cycles later.
  task automatic run_op(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] m,
                        input int want, input int interfere);
    exp_t         x;
    logic [N:0]   r;
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(posedge clk);
    #1;
    r     = ref_exp(b, e, m);
    x.res = (want >= 0) ? N'(want) : r[N-1:0];
    x.err = r[N];
    x.lat = (r[N] || m == 1 || e == 0) ? 2 : 2 + bit_len(e) * (N + 1);
    x.t0  = cyc;
    x.id  = op_id++;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    base = N'($urandom); exponent = N'($urandom); modulus = N'($urandom);
    if (interfere > 0) begin
      repeat (interfere) @(negedge clk);
      base = 16'd3; exponent = 16'd5; modulus = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check("timeout", n, 0);
      sb.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [N-1:0] m, b, e;
    int w;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_finish", finish, 0);
    check("reset_error", error, 0);

    // Basic operation, then confirm result holds across IDLE.
    run_op(16'd4, 16'd13, 16'd497, 445, 0);
    wait_done();
    repeat (10) @(negedge clk);
    check("hold_result", result, 445);

    // Round trip through a small RSA key.
    run_op(16'd65, 16'd17, 16'd3233, 2790, 0);
    wait_done();
    run_op(16'd2790, 16'd2753, 16'd3233, 65, 0);
    wait_done();

    // Early exits.
    run_op(16'd7, 16'd0, 16'd497, 1, 0);
    wait_done();
    run_op(16'd0, 16'd5, 16'd1, 0, 0);
    wait_done();
    run_op(16'd3, 16'd5, 16'd0, 0, 0);
    wait_done();
    run_op(16'd497, 16'd3, 16'd497, 0, 0);
    wait_done();
    check("error_hold", error, 1);

    // A start during MUL must be ignored.
    run_op(16'd4, 16'd13, 16'd497, 445, 20);
    wait_done();

    // Reset in the middle of an operation: no finish, and outputs return to reset values.
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (28) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_finish", finish, 0);
    check("abort_result", result, 0);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (finish || busy) n++;
    end
    check("abort_quiet", n, 0);
    run_op(16'd4, 16'd13, 16'd497, 445, 0);
    wait_done();

    // A start in the DONE cycle must be ignored.
    run_op(16'd5, 16'd3, 16'd23, 10, 0);
    n = 0;
    while (!finish && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", finish, 1);
    base = 16'd2; exponent = 16'd3; modulus = 16'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", busy, 0);
    repeat (3) @(negedge clk);
    check("done_start_result", result, 10);

    // When start and reset arrive together, reset wins.
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("start_reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("start_reset_busy2", busy, 0);

    // Full-width exponent: maximum latency.
    run_op(16'd65520, 16'hFFFF, 16'd65521, 65520, 0);
    wait_done();

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       m = N'($urandom_range(0, 1));
        1, 2:    m = N'($urandom_range(2, 20));
        3:       m = N'($urandom_range(32768, 65535));
        default: m = N'($urandom_range(2, 65535));
      endcase
      if ($urandom_range(0, 7) == 0) b = N'($urandom_range(int'(m), 65535));
      else if (m == 0)               b = N'($urandom_range(0, 65535));
      else                           b = N'($urandom_range(0, int'(m) - 1));
      w = $urandom_range(0, 16);
      e = N'($urandom & ((32'h1 << w) - 1));
      run_op(b, e, m, -1, 0);
      wait_done();
    end

    repeat (5) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
